// File: rtl/dmem_responder_if.sv
// MEM-stage data-memory request/response bundle between the core (master) and
// the data-memory responder (slave).
interface dmem_responder_if;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        mem_stall;
    logic        mem_ack;
    logic        mem_err;

    modport master (
        output mem_ren, mem_wen, mem_addr, mem_dout,
        input  mem_din, mem_stall, mem_ack, mem_err
    );

    modport slave (
        input  mem_ren, mem_wen, mem_addr, mem_dout,
        output mem_din, mem_stall, mem_ack, mem_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS MEM stage: fixed wait states, stall/ack handshake,
// saturating access counters. Define DMEM_ALIGN_CHECK_EN to flag and suppress misaligned accesses.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_responder_if.slave   bus,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic [ADDR_WIDTH-1:0]   lat_idx;
    logic [31:0]             lat_wdata;
    logic                    lat_write;
    logic                    lat_mis;
    logic [31:0]             din_q;
    logic                    ack_q;
    logic                    err_q;

    logic [31:0]             mem [0:DEPTH-1];

    logic                    req;
    logic [ADDR_WIDTH-1:0]   in_idx;
    logic                    in_mis;
    logic                    enter_done;
    logic [ADDR_WIDTH-1:0]   acc_idx;
    logic [31:0]             acc_wdata;
    logic                    acc_write;
    logic                    acc_mis;
    logic                    mem_we;
    logic                    unused_addr_bits;

    assign req    = bus.mem_ren | bus.mem_wen;
    assign in_idx = bus.mem_addr[ADDR_WIDTH+1:2];
    assign in_mis = ALIGN_CHECK && (bus.mem_addr[1:0] != 2'b00);

    // Upper address bits alias onto the array; byte-offset bits only matter with the check enabled.
    assign unused_addr_bits = (^bus.mem_addr[31:ADDR_WIDTH+2]) ^ (^bus.mem_addr[1:0]);

    // The access that completes on this edge: live inputs when zero wait states let IDLE
    // go straight to DONE, otherwise the values latched at acceptance.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        enter_done = 1'b0;
        acc_idx    = lat_idx;
        acc_wdata  = lat_wdata;
        acc_write  = lat_write;
        acc_mis    = lat_mis;
        case (state)
            IDLE: begin
                acc_idx    = in_idx;
                acc_wdata  = bus.mem_dout;
                acc_write  = bus.mem_wen;
                acc_mis    = in_mis;
                enter_done = req && (WAIT_CYCLES == 0);
            end
            BUSY:    enter_done = req && (cnt == 4'd1);
            default: enter_done = 1'b0;
        endcase
    end

    // Gated by rst_n so an edge seen while reset is held can never commit a write.
    assign mem_we = rst_n & enter_done & acc_write & ~acc_mis;

    // NOTE: the storage array has no reset; contents survive rst_n and power up unknown.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_idx   <= '0;
            lat_wdata <= 32'd0;
            lat_write <= 1'b0;
            lat_mis   <= 1'b0;
            din_q     <= 32'd0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_count  <= 16'd0;
            wr_count  <= 16'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every branch
            // below sees the pre-edge values regardless of statement order.
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (enter_done) begin
                ack_q <= 1'b1;
                err_q <= acc_mis;
                din_q <= (acc_write || acc_mis) ? 32'd0 : mem[acc_idx];
            end

            case (state)
                IDLE: begin
                    if (req) begin
                        lat_idx   <= in_idx;
                        lat_wdata <= bus.mem_dout;
                        lat_write <= bus.mem_wen;
                        lat_mis   <= in_mis;
                        if (WAIT_CYCLES == 0) begin
                            state <= DONE;
                        end else begin
                            state <= BUSY;
                            cnt   <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                BUSY: begin
                    if (!req) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'd1) begin
                        state <= DONE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (!lat_mis) begin
                        if (lat_write) begin
                            if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
                        end else begin
                            if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stall is combinational so the core freezes in the same cycle it raises a request.
    assign bus.mem_stall = rst_n & req & (state != DONE);
    assign bus.mem_din   = din_q;
    assign bus.mem_ack   = ack_q;
    assign bus.mem_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if bus_a ();
    dmem_responder_if bus_b ();

    logic        ren_a, wen_a, ren_b, wen_b;
    logic [31:0] addr_a, dout_a, addr_b, dout_b;
    logic [15:0] rd_a, wr_a, rd_b, wr_b;

    assign bus_a.mem_ren  = ren_a;
    assign bus_a.mem_wen  = wen_a;
    assign bus_a.mem_addr = addr_a;
    assign bus_a.mem_dout = dout_a;
    assign bus_b.mem_ren  = ren_b;
    assign bus_b.mem_wen  = wen_b;
    assign bus_b.mem_addr = addr_b;
    assign bus_b.mem_dout = dout_b;

    dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_a.slave),
        .rd_count (rd_a),
        .wr_count (wr_a)
    );

    dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_b.slave),
        .rd_count (rd_b),
        .wr_count (wr_b)
    );

`ifdef DMEM_ALIGN_CHECK_EN
    localparam logic        EXP_T7_ERR   = 1'b1;
    localparam logic [31:0] EXP_T7_WORD4 = 32'h1234_5678;
    localparam logic [15:0] EXP_T7_WR    = 16'd0;
`else
    localparam logic        EXP_T7_ERR   = 1'b0;
    localparam logic [31:0] EXP_T7_WORD4 = 32'hFFFF_FFFF;
    localparam logic [15:0] EXP_T7_WR    = 16'd1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request on instance sel (0=A, 1=B) and hold it until ack or a 20-cycle budget.
    task automatic access(input bit sel, input logic ren, input logic wen,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int stalls, output int ack_at);
        @(negedge clk);
        if (sel) begin
            ren_b = ren; wen_b = wen; addr_b = addr; dout_b = wdata;
        end else begin
            ren_a = ren; wen_a = wen; addr_a = addr; dout_a = wdata;
        end
        stalls = 0;
        ack_at = -1;
        rdata  = 32'd0;
        err    = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (sel ? bus_b.mem_ack : bus_a.mem_ack) begin
                ack_at = k;
                rdata  = sel ? bus_b.mem_din : bus_a.mem_din;
                err    = sel ? bus_b.mem_err : bus_a.mem_err;
                break;
            end
            if (sel ? bus_b.mem_stall : bus_a.mem_stall) stalls++;
            @(negedge clk);
        end
        if (sel) begin
            ren_b = 1'b0; wen_b = 1'b0;
        end else begin
            ren_a = 1'b0; wen_a = 1'b0;
        end
    endtask

    task automatic xfer(input string tag, input bit sel, input logic ren, input logic wen,
                        input logic [31:0] addr, input logic [31:0] wdata, input int lat,
                        input logic [31:0] exp_din, input logic exp_err);
        logic [31:0] rdata;
        logic        err;
        int          stalls;
        int          ack_at;
        access(sel, ren, wen, addr, wdata, rdata, err, stalls, ack_at);
        check({tag, ".ack_cycle"}, 32'(ack_at), 32'(lat));
        check({tag, ".stall_cycles"}, 32'(stalls), 32'(lat));
        check({tag, ".din"}, rdata, exp_din);
        check({tag, ".err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic check_counts(input string tag, input bit sel,
                                input logic [15:0] exp_rd, input logic [15:0] exp_wr);
        @(negedge clk);
        #1;
        check({tag, ".rd_count"}, 32'(sel ? rd_b : rd_a), 32'(exp_rd));
        check({tag, ".wr_count"}, 32'(sel ? wr_b : wr_a), 32'(exp_wr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic ack_seen;
        ren_a = 1'b0; wen_a = 1'b0; addr_a = 32'd0; dout_a = 32'd0;
        ren_b = 1'b0; wen_b = 1'b0; addr_b = 32'd0; dout_b = 32'd0;

        // Reset state; a request held during reset must not stall the core.
        repeat (2) @(negedge clk);
        ren_a = 1'b1;
        #1;
        check("rst.stall", 32'(bus_a.mem_stall), 32'd0);
        check("rst.ack", 32'(bus_a.mem_ack), 32'd0);
        check("rst.din", bus_a.mem_din, 32'd0);
        check("rst.err", 32'(bus_a.mem_err), 32'd0);
        check("rst.rd_count", 32'(rd_a), 32'd0);
        check("rst.wr_count", 32'(wr_a), 32'd0);
        ren_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle.stall", 32'(bus_a.mem_stall), 32'd0);

        // Write then read back with two wait states.
        xfer("t1_wr", 1'b0, 1'b0, 1'b1, 32'h10, 32'h1234_5678, 3, 32'd0, 1'b0);
        xfer("t1_rd", 1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 3, 32'h1234_5678, 1'b0);
        check_counts("t1", 1'b0, 16'd1, 16'd1);

        // Zero wait states: minimum two-cycle access.
        xfer("t2_wr", 1'b1, 1'b0, 1'b1, 32'h10, 32'h0BAD_0001, 1, 32'd0, 1'b0);
        xfer("t2_rd", 1'b1, 1'b1, 1'b0, 32'h10, 32'd0, 1, 32'h0BAD_0001, 1'b0);
        check_counts("t2", 1'b1, 16'd1, 16'd1);

        // 0x400 aliases word 0 with an 8-bit word index.
        xfer("t3_wr", 1'b0, 1'b0, 1'b1, 32'h400, 32'hCAFE_F00D, 3, 32'd0, 1'b0);
        xfer("t3_rd", 1'b0, 1'b1, 1'b0, 32'h000, 32'd0, 3, 32'hCAFE_F00D, 1'b0);
        check_counts("t3", 1'b0, 16'd2, 16'd2);

        xfer("t6_prep", 1'b0, 1'b0, 1'b1, 32'h30, 32'h1111_2222, 3, 32'd0, 1'b0);

        // Abort: request withdrawn in the first BUSY cycle.
        @(negedge clk);
        ren_a = 1'b1; addr_a = 32'h20;
        @(negedge clk);
        ren_a = 1'b0;
        ack_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1;
            ack_seen = ack_seen | bus_a.mem_ack;
        end
        check("t4.no_ack", 32'(ack_seen), 32'd0);
        check("t4.rd_count", 32'(rd_a), 32'd2);
        xfer("t4_rd", 1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 3, 32'h1234_5678, 1'b0);

        // Read and write together: write wins, din forced to 0, only wr_count moves.
        xfer("t5_both", 1'b0, 1'b1, 1'b1, 32'h8, 32'hA5A5_A5A5, 3, 32'd0, 1'b0);
        check_counts("t5", 1'b0, 16'd3, 16'd4);
        xfer("t5_rd", 1'b0, 1'b1, 1'b0, 32'h8, 32'd0, 3, 32'hA5A5_A5A5, 1'b0);

        // Reset pulse in the middle of a write discards it.
        @(negedge clk);
        wen_a = 1'b1; addr_a = 32'h30; dout_a = 32'h9999_9999;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6.stall", 32'(bus_a.mem_stall), 32'd0);
        check("t6.ack", 32'(bus_a.mem_ack), 32'd0);
        check("t6.din", bus_a.mem_din, 32'd0);
        check("t6.rd_count", 32'(rd_a), 32'd0);
        check("t6.wr_count", 32'(wr_a), 32'd0);
        @(negedge clk);
        wen_a = 1'b0;
        rst_n = 1'b1;
        xfer("t6_rd", 1'b0, 1'b1, 1'b0, 32'h30, 32'd0, 3, 32'h1111_2222, 1'b0);

        // Misaligned write to 0x13 targets word 4.
        xfer("t7_wr", 1'b0, 1'b0, 1'b1, 32'h13, 32'hFFFF_FFFF, 3, 32'd0, EXP_T7_ERR);
        xfer("t7_rd", 1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 3, EXP_T7_WORD4, 1'b0);
        check_counts("t7", 1'b0, 16'd2, EXP_T7_WR);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
